// File: rtl/mem_io_ctl_if.sv
// Bus bundle for the memory / memory-mapped I/O controller.
// The slave modport is the controller's view; the master modport is the
// view of everything around it (control unit, memory, keyboard, display).
interface mem_io_ctl_if;
  // control unit side
  logic        MIO_EN;
  logic        R_W;
  logic [15:0] MAR_OUT;
  logic [15:0] MDR_OUT;
  logic [15:0] MIOMUX_OUT;
  logic        R;
  // memory side
  logic        MEM_EN;
  logic        MEM_WE;
  logic [15:0] MEM_ADDR;
  logic [15:0] MEM_WDATA;
  logic [15:0] MEM_RDATA;
  // keyboard side
  logic [7:0]  KB_DATA;
  logic        KB_VALID;
  // display side
  logic [7:0]  DISP_DATA;
  logic        DISP_VALID;
  logic        DISP_ACK;
  // status debug taps
  logic [15:0] KBSR_OUT;
  logic [15:0] DSR_OUT;

  modport slave (
    input  MIO_EN, R_W, MAR_OUT, MDR_OUT, MEM_RDATA, KB_DATA, KB_VALID, DISP_ACK,
    output MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, MIOMUX_OUT, R,
    output DISP_DATA, DISP_VALID, KBSR_OUT, DSR_OUT
  );

  modport master (
    output MIO_EN, R_W, MAR_OUT, MDR_OUT, MEM_RDATA, KB_DATA, KB_VALID, DISP_ACK,
    input  MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, MIOMUX_OUT, R,
    input  DISP_DATA, DISP_VALID, KBSR_OUT, DSR_OUT
  );
endinterface

// File: rtl/mem_io_ctl.sv
// Memory / memory-mapped I/O controller.
// Accepts one access at a time from the control unit, routes it either to
// the external memory (MEM_LAT wait cycles) or to the keyboard/display
// registers, and pulses R for the single cycle the access completes.
// Latency counts the request cycle and the R cycle inclusively:
// device accesses take 2 cycles, memory accesses MEM_LAT+2.
module mem_io_ctl #(
  parameter int MEM_LAT = 2
) (
  input  logic          i_Clk,
  input  logic          i_Rst_n,
  mem_io_ctl_if.slave   bus
);

  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;
  localparam logic [3:0]  WAIT_LOAD = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    DONE     = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;

  // access latched when leaving IDLE; later input changes are ignored
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        we_q;

  // registered bus outputs
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] miomux;
  logic        r_pulse;

  // device register state
  logic        kb_ready;
  logic        kb_ie;
  logic [7:0]  kb_data;
  logic [7:0]  disp_data;
  logic        disp_valid;

  logic        is_dev;
  logic [15:0] kbsr;
  logic [15:0] dsr;
  logic [15:0] dev_rdata;
  logic        done_kbdr_read;
  logic        done_kbsr_write;
  logic        done_ddr_write;

  // DSR ready is simply "no character pending", so it cannot drift from DISP_VALID
  assign kbsr = {kb_ready, kb_ie, 14'b0};
  assign dsr  = {~disp_valid, 15'b0};

  assign done_kbdr_read  = (state == DONE) && !we_q && (addr_q == ADDR_KBDR);
  assign done_kbsr_write = (state == DONE) &&  we_q && (addr_q == ADDR_KBSR);
  assign done_ddr_write  = (state == DONE) &&  we_q && (addr_q == ADDR_DDR);

  // decode the requested address and select the device register read value
  always_comb begin
    is_dev    = 1'b0;
    dev_rdata = 16'h0000;
    case (bus.MAR_OUT)
      ADDR_KBSR: begin is_dev = 1'b1; dev_rdata = kbsr;             end
      ADDR_KBDR: begin is_dev = 1'b1; dev_rdata = {8'h00, kb_data}; end
      ADDR_DSR:  begin is_dev = 1'b1; dev_rdata = dsr;              end
      ADDR_DDR:  begin is_dev = 1'b1; dev_rdata = 16'h0000;         end
      default:   begin is_dev = 1'b0; dev_rdata = 16'h0000;         end
    endcase
  end

  // access sequencer: latches the request, runs the memory wait, pulses R
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      addr_q   <= 16'h0000;
      wdata_q  <= 16'h0000;
      we_q     <= 1'b0;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= 16'h0000;
      miomux   <= 16'h0000;
      r_pulse  <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.MIO_EN) begin
            addr_q  <= bus.MAR_OUT;
            wdata_q <= bus.MDR_OUT;
            we_q    <= bus.R_W;
            if (is_dev) begin
              // device registers answer immediately; snapshot read data now
              state   <= DONE;
              r_pulse <= 1'b1;
              if (!bus.R_W) begin
                miomux <= dev_rdata;
              end
            end else begin
              state    <= MEM_WAIT;
              wait_cnt <= WAIT_LOAD;
              mem_en   <= 1'b1;
              mem_we   <= bus.R_W;
              mem_addr <= bus.MAR_OUT;
            end
          end
        end
        MEM_WAIT: begin
          if (wait_cnt == 4'd0) begin
            // last wait cycle: memory data is valid now
            state    <= DONE;
            r_pulse  <= 1'b1;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= 16'h0000;
            if (!we_q) begin
              miomux <= bus.MEM_RDATA;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // keyboard and display registers; access side effects land at the end of DONE
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      kb_ready   <= 1'b0;
      kb_ie      <= 1'b0;
      kb_data    <= 8'h00;
      disp_data  <= 8'h00;
      disp_valid <= 1'b0;
    end else begin
      // a fresh character wins over the read-clear so it is never lost
      if (bus.KB_VALID && (!kb_ready || done_kbdr_read)) begin
        kb_data  <= bus.KB_DATA;
        kb_ready <= 1'b1;
      end else if (done_kbdr_read) begin
        kb_ready <= 1'b0;
      end

      if (done_kbsr_write) begin
        kb_ie <= wdata_q[14];
      end

      // a DDR write can only succeed while nothing is pending, so it never
      // collides with an acknowledge on the same edge
      if (disp_valid && bus.DISP_ACK) begin
        disp_valid <= 1'b0;
      end else if (done_ddr_write && !disp_valid) begin
        disp_data  <= wdata_q[7:0];
        disp_valid <= 1'b1;
      end
    end
  end

  assign bus.MEM_EN     = mem_en;
  assign bus.MEM_WE     = mem_we;
  assign bus.MEM_ADDR   = mem_addr;
  assign bus.MEM_WDATA  = wdata_q;
  assign bus.MIOMUX_OUT = miomux;
  assign bus.R          = r_pulse;
  assign bus.DISP_DATA  = disp_data;
  assign bus.DISP_VALID = disp_valid;
  assign bus.KBSR_OUT   = kbsr;
  assign bus.DSR_OUT    = dsr;

endmodule

// File: doc/mem_io_ctl.md
MEM_IO_CTL -- requirements
Module: mem_io_ctl

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, memory wait cycles per access (legal 1..15).
REQ-002 SHALL have one clock and an asynchronous active-low reset: i_Clk, rising edge, sole clock; i_Rst_n, asynchronous assert, active low.
REQ-003 SHALL have ports (name direction width meaning):
- i_Clk  in  1  clock
- i_Rst_n  in  1  async reset, active low
- MIO_EN  in  1  access request, held by control until R
- R_W  in  1  1=write, 0=read
- MAR_OUT  in  16  access address
- MDR_OUT  in  16  write data
- MEM_RDATA  in  16  memory read data
- KB_DATA  in  8  keyboard character
- KB_VALID  in  1  one-cycle character strobe
- DISP_ACK  in  1  display consumed DISP_DATA
- MEM_EN  out  1  memory enable
- MEM_WE  out  1  memory write enable
- MEM_ADDR  out  16  memory address
- MEM_WDATA  out  16  memory write data
- MIOMUX_OUT  out  16  read data to MDR, registered
- R  out  1  access-complete pulse
- DISP_DATA  out  8  character to display
- DISP_VALID  out  1  character pending
- KBSR_OUT, DSR_OUT  out  16 each  status register values (debug)

Function
REQ-004 SHALL decode device registers: KBSR=xFE00, KBDR=xFE02, DSR=xFE04, DDR=xFE06; all other addresses are memory.
REQ-005 SHALL implement FSM IDLE, MEM_WAIT, DONE; IDLE->DONE if MIO_EN and device address; IDLE->MEM_WAIT if MIO_EN and memory address; MEM_WAIT->DONE after MEM_LAT cycles; DONE->IDLE unconditionally.
REQ-006 SHALL assert R for exactly the one cycle the FSM is in DONE; MIOMUX_OUT SHALL be valid in that cycle and held until the next read completes.
REQ-007 SHALL latch MAR_OUT, MDR_OUT and R_W on leaving IDLE; later input changes SHALL not affect the access in flight.
REQ-008 SHALL drive MEM_EN=1, MEM_ADDR=latched address and MEM_WE=latched R_W only in MEM_WAIT, and MEM_WDATA=latched data; MEM_RDATA SHALL be captured on the last MEM_WAIT cycle.
REQ-009 Device read latency SHALL be 2 cycles (request accepted to R); memory latency SHALL be MEM_LAT+2 cycles.
REQ-010 KBSR SHALL hold bit15=ready, bit14=IE, other bits 0; KBDR SHALL be {8'h00, last character}.
REQ-011 On KB_VALID with KBSR[15]=0: KBDR<=KB_DATA, KBSR[15]<=1; with KBSR[15]=1 the character SHALL be dropped.
REQ-012 A completed KBDR read SHALL clear KBSR[15]; if KB_VALID occurs in the same cycle, the new character SHALL load and KBSR[15] SHALL end at 1, while the read returns the old KBDR.
REQ-013 A write to KBSR SHALL update only bit14; writes to KBDR and DSR SHALL be ignored but still complete with R.
REQ-014 DSR SHALL hold bit15=ready, other bits 0; reads of DDR SHALL return 16'h0000.
REQ-015 A DDR write with DSR[15]=1 SHALL set DISP_DATA<=MDR[7:0], DISP_VALID<=1 and DSR[15]<=0 on the DONE cycle.
REQ-016 A DDR write with DSR[15]=0 SHALL be dropped but complete with R.
REQ-017 DISP_VALID SHALL hold until DISP_ACK is sampled high, then clear, and DSR[15] SHALL return to 1 on the same edge; DISP_ACK with DISP_VALID=0 SHALL be ignored.

Reset
REQ-018 Asserting i_Rst_n low SHALL immediately force: FSM=IDLE, R=0, MEM_EN=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, MIOMUX_OUT=0, KBSR=0, KBDR=0, DSR=x8000, DISP_DATA=0, DISP_VALID=0.
REQ-019 Reset during MEM_WAIT or with a character pending SHALL abort without R or DISP_ACK; the aborted access SHALL not be retried.

Verification
REQ-020 Memory read x3000, MEM_LAT=2, MEM_RDATA=x1234 -> MEM_EN high 2 cycles; R pulse at cycle 4; MIOMUX_OUT=x1234.
REQ-021 KB_VALID with KB_DATA=x41, then read xFE00 and xFE02, then read xFE00 -> x8000, x0041, x0000.
REQ-022 Two KB_VALID (x41, x42) without an intervening read, then read KBDR -> x0041 (x42 dropped).
REQ-023 Write xFE06 with x0048 -> DISP_VALID=1, DISP_DATA=x48, DSR reads x0000; a second DDR write is ignored; DISP_ACK -> DSR=x8000.
REQ-024 KB_VALID coincident with KBDR read completion -> read returns old char; KBSR[15]=1; KBDR=new char.
REQ-025 i_Rst_n low mid-MEM_WAIT with DISP_VALID=1 -> all outputs at reset values asynchronously; no R pulse after release.
